ble_uart_cmd_framer: RTL
========================

// Module: ble_uart_cmd_framer
// PURPOSE
//  Upstream of the BLE UART command decoder. Collects raw bytes from the UART RX
//  byte strobe into one command frame: opcode, 6-byte address, length byte,
//  0..MAX_PAYLOAD payload bytes. Presents the packed frame plus a 1-cycle start
//  pulse to the decoder. Discards malformed, over-length and stalled frames.
// PARAMETERS
//  MAX_PAYLOAD     8      max payload bytes; FRAME_W = 64 + 8*MAX_PAYLOAD
//  TIMEOUT_CYCLES  50000  inter-byte gap (clk cycles) that aborts a partial frame
//  ACK_HOLD        4      cycles held after frame_start before re-checking dec_done
// PORTS
//  clk           in   1        system clock
//  reset_n       in   1        asynchronous, active-low reset
//  rx_data       in   8        received UART byte
//  rx_valid      in   1        1-cycle strobe: rx_data valid
//  rx_error      in   1        UART framing/parity error, qualified by rx_valid
//  dec_done      in   1        decoder idle/ready (high = may start)
//  frame_data    out  FRAME_W  packed frame; byte k at [8k+7:8k]
//  frame_start   out  1        1-cycle pulse: frame_data valid, start decoder
//  busy          out  1        high whenever state != IDLE
//  err_timeout   out  1        1-cycle pulse: partial frame aborted on gap
//  err_overlen   out  1        1-cycle pulse: length byte > MAX_PAYLOAD
//  err_rx        out  1        1-cycle pulse: rx_error during a frame
//  drop_count    out  8        saturating count of discarded bytes
// BEHAVIOUR
//  Reset: all outputs 0, byte index 0, gap timer 0, state IDLE. Async assert,
//   sync release. Reset mid-frame discards the partial frame; no pulses issued.
//  Frame layout: byte0 opcode [7:0]; bytes1-6 address [55:8], first-received at
//   [15:8]; byte7 length L [63:56]; payload byte i at [71+8i:64+8i].
//   Unused payload bits are zero.
//  States:
//   IDLE    rx_valid -> store opcode, clear unused payload bits -> ADDR
//   ADDR    6 bytes counted -> LEN
//   LEN     L>MAX_PAYLOAD -> err_overlen, FLUSH; L==0 -> ISSUE; else PAYLOAD
//   PAYLOAD L bytes counted -> ISSUE
//   ISSUE   dec_done=1 -> frame_start=1 for exactly 1 cycle -> ACK; else wait
//   ACK     wait ACK_HOLD cycles, then dec_done=1 -> IDLE
//   FLUSH   drop every byte; gap of TIMEOUT_CYCLES with no rx_valid -> IDLE
//  Latency: frame_start asserts on the cycle after the final byte's rx_valid
//   when dec_done=1.
//  frame_data only changes while capturing. It is stable from frame_start until
//   the next frame's opcode byte.
//  Gap timer: runs in ADDR/LEN/PAYLOAD/FLUSH. Cleared by every rx_valid. Reaching
//   TIMEOUT_CYCLES-1 in a capture state -> err_timeout, IDLE.
//  rx_valid & rx_error in a capture state -> err_rx, byte dropped, FLUSH.
//   In IDLE the byte is dropped and the state stays IDLE.
//  Bytes arriving in ISSUE/ACK/FLUSH are dropped; drop_count += 1, saturates at 255.
//  Simultaneous events: rx_valid in the same cycle as the timeout beats the
//   timeout (timer clears). rx_error beats a normal byte. Errors are one-hot
//   per cycle.
// STRUCTURE
//  Package ble_uart_cmd_pkg: state enum, OPC_DISABLE_ENC=8'h01,
//   OPC_READ_YAW=8'h03, ADDR_BYTES=6, HDR_BYTES=8, broadcast addr 48'hFFFFFFFFFFFF.
//  Sub-module ble_uart_gap_timer: clear/enable inputs, expired output; TIMEOUT
//   counter width = $clog2(TIMEOUT_CYCLES).
// TESTING
//  1 dec_done=1; bytes 01,FF x6,01,00 -> one frame_start the next cycle;
//    frame_data[71:0]=72'h00_01_FFFFFFFFFFFF_01; upper bits 0.
//  2 bytes 03,11,22,33,44,55,66,00 -> frame_data[55:8]=48'h665544332211,
//    [63:56]=0, frame_start once.
//  3 3 bytes then TIMEOUT_CYCLES idle -> err_timeout pulse, no frame_start,
//    busy=0; the next full frame is accepted normally.
//  4 header with L=9 -> err_overlen; 5 trailing bytes dropped (drop_count=5);
//    IDLE after the gap.
//  5 dec_done=0 at frame end -> no start; 2 bytes arrive (drop_count=2);
//    dec_done=1 -> frame_start the next cycle.
//  6 reset_n low after 4 bytes -> outputs 0 immediately, no pulses; a clean
//    frame after release decodes correctly.

Source files
------------

// File: rtl/ble_uart_cmd_pkg.sv
// Shared types and constants for the BLE UART command framer.
package ble_uart_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_LEN,
        ST_PAYLOAD,
        ST_ISSUE,
        ST_ACK,
        ST_FLUSH
    } state_e;

    localparam logic [7:0]  OPC_DISABLE_ENC = 8'h01;
    localparam logic [7:0]  OPC_READ_YAW    = 8'h03;
    localparam int          ADDR_BYTES      = 6;
    localparam int          HDR_BYTES       = 8;
    localparam logic [47:0] ADDR_BROADCAST  = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/ble_uart_gap_timer.sv
// Inter-byte gap timer: counts idle cycles while enabled, flags when the gap
// limit is reached.
module ble_uart_gap_timer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || !enable_i) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = enable_i && (cnt_q == CNT_LAST);

endmodule

// File: rtl/ble_uart_cmd_framer.sv
// Assembles UART RX bytes into opcode/address/length/payload command frames
// and hands each complete frame to the decoder with a one-cycle start pulse.
module ble_uart_cmd_framer
    import ble_uart_cmd_pkg::*;
#(
    parameter int MAX_PAYLOAD    = 8,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int ACK_HOLD       = 4,
    localparam int FRAME_W       = 64 + 8 * MAX_PAYLOAD
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               rx_error,
    input  logic               dec_done,
    output logic [FRAME_W-1:0] frame_data,
    output logic               frame_start,
    output logic               busy,
    output logic               err_timeout,
    output logic               err_overlen,
    output logic               err_rx,
    output logic [7:0]         drop_count
);

    localparam int               FRAME_BYTES = HDR_BYTES + MAX_PAYLOAD;
    localparam int               HOLD_W      = (ACK_HOLD > 1) ? $clog2(ACK_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(ACK_HOLD - 1);
    localparam logic [7:0]       MAX_LEN     = 8'(MAX_PAYLOAD);
    localparam logic [7:0]       LAST_HDR    = 8'(HDR_BYTES - 1);
    localparam logic [7:0]       LAST_ADDR   = 8'(ADDR_BYTES);

    state_e              state_q, state_d;
    logic [7:0]          idx_q, idx_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [7:0]          drop_q, drop_d;
    logic                err_to_q, err_to_d;
    logic                err_ol_q, err_ol_d;
    logic                err_rx_q, err_rx_d;
    logic                start_c;
    logic                drop_c;
    logic                wr_en;
    logic                timer_en;
    logic                timer_expired;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign timer_en = (state_q inside {ST_ADDR, ST_LEN, ST_PAYLOAD, ST_FLUSH});

    ble_uart_gap_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_gap_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (rx_valid),
        .enable_i (timer_en),
        .expired_o(timer_expired)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        hold_d   = hold_q;
        frame_d  = frame_q;
        err_to_d = 1'b0;
        err_ol_d = 1'b0;
        err_rx_d = 1'b0;
        start_c  = 1'b0;
        drop_c   = 1'b0;
        wr_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (rx_error) begin
                        drop_c = 1'b1;
                    end else begin
                        frame_d      = '0;
                        frame_d[7:0] = rx_data;
                        idx_d        = 8'd1;
                        state_d      = ST_ADDR;
                    end
                end
            end
            ST_ADDR, ST_LEN, ST_PAYLOAD: begin
                if (rx_valid) begin
                    if (rx_error) begin
                        err_rx_d = 1'b1;
                        drop_c   = 1'b1;
                        state_d  = ST_FLUSH;
                    end else begin
                        wr_en = 1'b1;
                        idx_d = idx_q + 8'd1;
                        if (state_q == ST_ADDR) begin
                            if (idx_q == LAST_ADDR) state_d = ST_LEN;
                        end else if (state_q == ST_LEN) begin
                            if (rx_data > MAX_LEN) begin
                                err_ol_d = 1'b1;
                                state_d  = ST_FLUSH;
                            end else if (rx_data == 8'd0) begin
                                state_d = ST_ISSUE;
                            end else begin
                                state_d = ST_PAYLOAD;
                            end
                        end else if (idx_q == LAST_HDR + frame_q[63:56]) begin
                            state_d = ST_ISSUE;
                        end
                    end
                end else if (timer_expired) begin
                    err_to_d = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                drop_c = rx_valid;
                if (dec_done) begin
                    start_c = 1'b1;
                    hold_d  = '0;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                drop_c = rx_valid;
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end else if (dec_done) begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (rx_valid) begin
                    drop_c = 1'b1;
                end else if (timer_expired) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Byte 0 is written by the IDLE branch; later bytes land at their index.
        if (wr_en) begin
            for (int k = 1; k < FRAME_BYTES; k++) begin
                if (idx_q == 8'(k)) frame_d[8*k +: 8] = rx_data;
            end
        end

        drop_d = drop_c ? sat_inc8(drop_q) : drop_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            hold_q   <= '0;
            frame_q  <= '0;
            drop_q   <= '0;
            err_to_q <= 1'b0;
            err_ol_q <= 1'b0;
            err_rx_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            hold_q   <= hold_d;
            frame_q  <= frame_d;
            drop_q   <= drop_d;
            err_to_q <= err_to_d;
            err_ol_q <= err_ol_d;
            err_rx_q <= err_rx_d;
        end
    end

    assign frame_data  = frame_q;
    assign frame_start = start_c;
    assign busy        = (state_q != ST_IDLE);
    assign err_timeout = err_to_q;
    assign err_overlen = err_ol_q;
    assign err_rx      = err_rx_q;
    assign drop_count  = drop_q;

endmodule
